alu_mdu_ctrl: RTL and testbench

//  Next-generation ALU control. Decodes aluop/opcode/funct into a widened ALU control word and flags illegal

---
 rtl/alu_mdu_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_mdu_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: EX-stage ALU control decoder with an iterative multiply/divide
// unit (MDU) that holds the HI/LO registers and stalls dependent MDU instructions.
module alu_mdu_ctrl #(
   parameter int WIDTH     = 32,
   parameter int ALUCTRL_W = 4,
   parameter bit MDU_EN    = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 valid_i,
   input  logic [5:0]           opcode_i,
   input  logic [5:0]           funct_i,
   input  logic [1:0]           aluop_i,
   input  logic [WIDTH-1:0]     srca_i,
   input  logic [WIDTH-1:0]     srcb_i,
   output logic [ALUCTRL_W-1:0] alucontrol_o,
   output logic                 illegal_o,
   output logic                 mdu_sel_o,
   output logic [WIDTH-1:0]     mdu_result_o,
   output logic                 mdu_busy_o,
   output logic                 stall_o,
   output logic                 div_zero_o,
   output logic [WIDTH-1:0]     hi_o,
   output logic [WIDTH-1:0]     lo_o
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [2*WIDTH-1:0] acc_q;     // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opnd_q;    // mult: |multiplicand|; div: |divisor|
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               is_div_q, neg_q, rsign_q, dz_q;

   logic [3:0] dec_code;
   logic       dec_legal, mdu_class;

   // Decode aluop/opcode/funct; unknown encodings leave code 0000 and legal low.
   always_comb begin
      dec_code  = OP_AND;
      dec_legal = 1'b0;
      mdu_class = 1'b0;
      case (aluop_i)
         2'b00: begin dec_code = OP_ADD; dec_legal = 1'b1; end
         2'b01: begin dec_code = OP_SUB; dec_legal = 1'b1; end
         2'b10: begin
            case (funct_i)
               6'b100000: begin dec_code = OP_ADD;  dec_legal = 1'b1; end
               6'b100010: begin dec_code = OP_SUB;  dec_legal = 1'b1; end
               6'b100100: begin dec_code = OP_AND;  dec_legal = 1'b1; end
               6'b100101: begin dec_code = OP_OR;   dec_legal = 1'b1; end
               6'b100110: begin dec_code = OP_XOR;  dec_legal = 1'b1; end
               6'b100111: begin dec_code = OP_NOR;  dec_legal = 1'b1; end
               6'b101010: begin dec_code = OP_SLT;  dec_legal = 1'b1; end
               6'b101011: begin dec_code = OP_SLTU; dec_legal = 1'b1; end
               6'b011000, 6'b011001, 6'b011010, 6'b011011,
               6'b010000, 6'b010001, 6'b010010, 6'b010011: begin
                  if (MDU_EN) begin
                     dec_code  = OP_ADD;
                     dec_legal = 1'b1;
                     mdu_class = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         2'b11: begin
            case (opcode_i)
               6'b001000: begin dec_code = OP_ADD;  dec_legal = 1'b1; end
               6'b001100: begin dec_code = OP_AND;  dec_legal = 1'b1; end
               6'b001101: begin dec_code = OP_OR;   dec_legal = 1'b1; end
               6'b001110: begin dec_code = OP_XOR;  dec_legal = 1'b1; end
               6'b001010: begin dec_code = OP_SLT;  dec_legal = 1'b1; end
               6'b001011: begin dec_code = OP_SLTU; dec_legal = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // MDU funct sub-decode; only meaningful when mdu_class is high.
   logic f_muldiv, f_div, f_signed, f_mfhi, f_mthi, f_mflo, f_mtlo;
   assign f_muldiv = (funct_i[5:2] == 4'b0110);
   assign f_div    = funct_i[1];
   assign f_signed = ~funct_i[0];
   assign f_mfhi   = (funct_i == 6'b010000);
   assign f_mthi   = (funct_i == 6'b010001);
   assign f_mflo   = (funct_i == 6'b010010);
   assign f_mtlo   = (funct_i == 6'b010011);

   logic busy, accept, start;
   assign busy   = (state_q != S_IDLE);
   assign stall_o = valid_i & mdu_class & busy;
   assign accept = valid_i & mdu_class & ~stall_o & ~reset_i;
   assign start  = accept & f_muldiv;

   // Unsigned ops never see a sign flag, so their magnitudes are the raw operands.
   logic             sa, sb;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign sa    = f_signed & srca_i[WIDTH-1];
   assign sb    = f_signed & srcb_i[WIDTH-1];
   assign a_mag = sa ? -srca_i : srca_i;
   assign b_mag = sb ? -srcb_i : srcb_i;

   // One iteration: shift-add for multiply, restoring subtract for divide.
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] acc_step;
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = ~div_diff[WIDTH];
      if (is_div_q)
         acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
      else
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Sign correction applied in FIX. A zero divisor keeps the all-ones quotient,
   // and the remainder then restores the original dividend.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      if (is_div_q) begin
         fix_lo = (neg_q & ~dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         fix_hi = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end else begin
         fix_lo = prod_fix[WIDTH-1:0];
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   // MDU state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // MDU next state: IDLE -> RUN for WIDTH steps -> FIX -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (count_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // MDU datapath and HI/LO; reset drops any in-flight operation.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q  <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rsign_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  count_q  <= '0;
                  is_div_q <= f_div;
                  neg_q    <= sa ^ sb;
                  rsign_q  <= sa;
                  dz_q     <= f_div & (srcb_i == '0);
                  if (f_div) begin
                     acc_q  <= {{WIDTH{1'b0}}, a_mag};
                     opnd_q <= b_mag;
                  end else begin
                     acc_q  <= {{WIDTH{1'b0}}, b_mag};
                     opnd_q <= a_mag;
                  end
               end
               if (accept & f_mthi) hi_q <= srca_i;
               if (accept & f_mtlo) lo_q <= srca_i;
            end
            S_RUN: begin
               acc_q   <= acc_step;
               count_q <= count_q + 1'b1;
            end
            S_FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign alucontrol_o = ALUCTRL_W'(dec_code);
   assign illegal_o    = valid_i & ~dec_legal;
   assign mdu_sel_o    = valid_i & mdu_class & (f_mfhi | f_mflo);
   assign mdu_result_o = ~mdu_sel_o ? '0 : (f_mfhi ? hi_q : lo_q);
   assign mdu_busy_o   = busy;
   assign div_zero_o   = (state_q == S_FIX) & is_div_q & dz_q;
   assign hi_o         = hi_q;
   assign lo_o         = lo_q;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Scoreboard bench for alu_mdu_ctrl: stimulus pushes per-cycle expectations and
// MDU results from a plain-arithmetic reference model; a monitor pops and compares.
module tb_alu_mdu_ctrl;
   localparam int W = 32;

   logic        clk = 1'b0;
   logic        reset, valid;
   logic [5:0]  opcode, funct;
   logic [1:0]  aluop;
   logic [31:0] srca, srcb;
   logic [3:0]  alucontrol;
   logic        illegal, mdu_sel, mdu_busy, stall, div_zero;
   logic [31:0] mdu_result, hi, lo;

   always #5 clk = ~clk;

   alu_mdu_ctrl #(.WIDTH(W), .ALUCTRL_W(4), .MDU_EN(1'b1)) dut (
      .clk_i(clk), .reset_i(reset), .valid_i(valid), .opcode_i(opcode), .funct_i(funct),
      .aluop_i(aluop), .srca_i(srca), .srcb_i(srcb), .alucontrol_o(alucontrol),
      .illegal_o(illegal), .mdu_sel_o(mdu_sel), .mdu_result_o(mdu_result),
      .mdu_busy_o(mdu_busy), .stall_o(stall), .div_zero_o(div_zero), .hi_o(hi), .lo_o(lo)
   );

   typedef struct packed {
      logic [3:0] ac; logic ill; logic sel; logic [31:0] res;
      logic stl; logic bsy; logic dz; logic [31:0] hi; logic [31:0] lo;
   } exp_t;
   typedef struct packed { logic [31:0] hi; logic [31:0] lo; } res_t;

   exp_t dq[$];
   res_t rq[$];
   int   n_chk = 0, n_fail = 0;
   bit   done = 0, final_done = 0;

   // Reference model state: architectural HI/LO plus a busy countdown.
   int          busy_cnt = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   bit          p_dz = 0;

   logic [5:0] mdu_fn[8] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h11, 6'h12, 6'h13};
   logic [5:0] alu_fn[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_decode(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                                      output logic [3:0] ac, output bit legal, output bit mdu);
      ac = 4'h0; legal = 1'b1; mdu = 1'b0;
      case (op)
         2'b00: ac = 4'h2;
         2'b01: ac = 4'h6;
         2'b10: case (fn)
            6'h20: ac = 4'h2;  6'h22: ac = 4'h6;  6'h24: ac = 4'h0;  6'h25: ac = 4'h1;
            6'h26: ac = 4'h3;  6'h27: ac = 4'h4;  6'h2a: ac = 4'h7;  6'h2b: ac = 4'h5;
            6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h11, 6'h12, 6'h13: begin ac = 4'h2; mdu = 1'b1; end
            default: legal = 1'b0;
         endcase
         default: case (opc)
            6'h08: ac = 4'h2;  6'h0c: ac = 4'h0;  6'h0d: ac = 4'h1;
            6'h0e: ac = 4'h3;  6'h0a: ac = 4'h7;  6'h0b: ac = 4'h5;
            default: legal = 1'b0;
         endcase
      endcase
   endfunction

   function automatic res_t ref_mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      res_t r; longint p; logic [63:0] u; int ia, ib;
      ia = a; ib = b;
      r = '0;
      case (fn)
         6'h18: begin p = longint'(ia) * longint'(ib); {r.hi, r.lo} = p; end
         6'h19: begin u = {32'h0, a} * {32'h0, b}; {r.hi, r.lo} = u; end
         6'h1a: begin
            if (b == 0)                                 begin r.hi = a; r.lo = 32'hFFFFFFFF; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r.hi = 0; r.lo = a; end
            else begin r.lo = ia / ib; r.hi = ia % ib; end
         end
         default: begin
            if (b == 0) begin r.hi = a; r.lo = 32'hFFFFFFFF; end
            else begin r.lo = a / b; r.hi = a % b; end
         end
      endcase
      return r;
   endfunction

   // One clock cycle: drive inputs, push expectations, then advance the model at the edge.
   task automatic cyc(input bit rst, input bit v, input logic [1:0] op, input logic [5:0] opc,
                      input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      exp_t e; logic [3:0] ac; bit legal, mdu, stl; res_t r;
      reset = rst; valid = v; aluop = op; opcode = opc; funct = fn; srca = a; srcb = b;
      ref_decode(op, opc, fn, ac, legal, mdu);
      stl   = v && mdu && (busy_cnt > 0);
      e.ac  = ac;
      e.ill = v && !legal;
      e.sel = v && mdu && (fn == 6'h10 || fn == 6'h12);
      e.res = !e.sel ? 32'h0 : ((fn == 6'h10) ? m_hi : m_lo);
      e.stl = stl;
      e.bsy = (busy_cnt > 0);
      e.dz  = (busy_cnt == 1) && p_dz;
      e.hi  = m_hi;
      e.lo  = m_lo;
      dq.push_back(e);
      @(posedge clk);
      if (rst) begin
         if (busy_cnt > 0) rq[rq.size()-1] = '{hi: 32'h0, lo: 32'h0};
         busy_cnt = 0; p_dz = 0; m_hi = 0; m_lo = 0;
      end else begin
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; p_dz = 0; end
         end
         if (v && mdu && !stl) begin
            case (fn)
               6'h18, 6'h19, 6'h1a, 6'h1b: begin
                  r = ref_mdu(fn, a, b);
                  p_hi = r.hi; p_lo = r.lo;
                  p_dz = fn[1] && (b == 0);
                  busy_cnt = W + 1;
                  rq.push_back(r);
               end
               6'h11: m_hi = a;
               6'h13: m_lo = a;
               default: ;
            endcase
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 2'($urandom), 6'($urandom), 6'($urandom), $urandom, $urandom);
   endtask

   task automatic mdu_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      cyc(0, 1, 2'b10, 6'h00, fn, a, b);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: per-cycle expectations, and MDU results whenever busy falls.
   initial begin : monitor
      exp_t e; res_t r; bit bprev;
      bprev = 1'b0;
      forever begin
         @(negedge clk);
         if (dq.size() > 0) begin
            e = dq.pop_front();
            check("decode",   {alucontrol, illegal},        {e.ac, e.ill});
            check("mdu_read", {mdu_sel, mdu_result},        {e.sel, e.res});
            check("ctrl",     {stall, mdu_busy, div_zero},  {e.stl, e.bsy, e.dz});
            check("hilo",     {hi, lo},                     {e.hi, e.lo});
         end
         if (bprev && !mdu_busy) begin
            if (rq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL result_queue: busy fell with no pending result at %0t", $time);
            end else begin
               r = rq.pop_front();
               check("mdu_result", {hi, lo}, {r.hi, r.lo});
            end
         end
         bprev = mdu_busy;
         if (done && !final_done) begin
            check("leftover_results", 64'(rq.size()), 64'd0);
            final_done = 1;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset = 1; valid = 0; aluop = 0; opcode = 0; funct = 0; srca = 0; srcb = 0;
      @(posedge clk); #1;
      cyc(1, 0, 2'b00, 6'h0, 6'h0, 32'h0, 32'h0);

      // Decode sweep over every aluop/opcode/funct, then an explicit illegal funct.
      cyc(0, 1, 2'b00, 6'($urandom), 6'($urandom), $urandom, $urandom);
      cyc(0, 1, 2'b01, 6'($urandom), 6'($urandom), $urandom, $urandom);
      for (int f = 0; f < 64; f++) cyc(0, 1, 2'b10, 6'($urandom), 6'(f), $urandom, $urandom);
      for (int o = 0; o < 64; o++) cyc(0, 1, 2'b11, 6'(o), 6'($urandom), $urandom, $urandom);
      cyc(0, 1, 2'b10, 6'h00, 6'h3f, 32'h0, 32'h0);
      idle(40);

      // Directed multiply/divide cases.
      mdu_op(6'h18, 32'd7, 32'hFFFFFFFD);          idle(34);
      mdu_op(6'h19, 32'd7, 32'hFFFFFFFD);          idle(34);
      mdu_op(6'h1a, 32'hFFFFFFF9, 32'd2);          idle(34);
      mdu_op(6'h1a, 32'h80000000, 32'hFFFFFFFF);   idle(34);
      mdu_op(6'h1b, 32'h1234, 32'h0);              idle(34);
      mdu_op(6'h1a, 32'hFFFFFFF9, 32'h0);          idle(34);

      // MFLO right behind a MULT stalls until the new LO is visible.
      mdu_op(6'h18, 32'h12345, 32'hFFFF0003);
      repeat (34) mdu_op(6'h12, 32'h0, 32'h0);
      idle(2);

      // Non-MDU instructions proceed while the MDU is busy.
      mdu_op(6'h1b, 32'hDEADBEEF, 32'd13);
      repeat (5) cyc(0, 1, 2'b10, 6'h00, 6'h20, $urandom, $urandom);
      idle(30);

      // MTHI/MTLO then read back.
      mdu_op(6'h11, 32'hA5A5A5A5, 32'h0);
      mdu_op(6'h13, 32'h5A5A5A5A, 32'h0);
      mdu_op(6'h10, 32'h0, 32'h0);
      mdu_op(6'h12, 32'h0, 32'h0);

      // Reset mid-RUN at count 10 discards the op; a following MULT still works.
      mdu_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      idle(10);
      cyc(1, 0, 2'b00, 6'h0, 6'h0, 32'h0, 32'h0);
      idle(1);
      mdu_op(6'h18, 32'd3, 32'd5);
      idle(34);
      mdu_op(6'h12, 32'h0, 32'h0);

      // Randomized mix.
      for (int i = 0; i < 600; i++) begin
         logic [1:0] op; logic [5:0] fn;
         op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         case ($urandom_range(0, 3))
            0: fn = 6'($urandom);
            1: fn = alu_fn[$urandom_range(0, 7)];
            default: fn = mdu_fn[$urandom_range(0, 7)];
         endcase
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), op, 6'($urandom), fn,
             rand_opnd(), rand_opnd());
      end
      idle(40);

      done = 1;
      @(negedge clk); @(negedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
